pipo_register: RTL and testbench

PIPO_REGISTER -- requirements
Module: pipo_register

---
 rtl/pipo_register.sv | 39 +++
 tb/tb_pipo_register.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipo_register.sv
// pipo_register
//   Parallel-in / parallel-out register pipeline. DEPTH stages of WIDTH bits
//   are loaded on every rising clock edge. The output is taken straight from
//   the last stage, so inputseq has no combinational path to answer.
//   Reset is asynchronous and active-low. It forces every stage to
//   RESET_VALUE, which discards any data still in flight.
//   Port order is fixed so that positional instantiation binds correctly.
module pipo_register #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] inputseq,
  output logic [WIDTH-1:0] answer,
  input  logic             reset,
  input  logic             clock
);

  // r_stage[0] is the capture stage and r_stage[DEPTH-1] drives the output.
  logic [WIDTH-1:0] r_stage [DEPTH];

  // Stage shift. Every edge loads the whole word at once, so bits are never
  // shifted, masked or reordered. Reset clears the full pipeline.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= RESET_VALUE;
      end
    end else begin
      r_stage[0] <= inputseq;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign answer = r_stage[DEPTH-1];

endmodule

// File: tb/tb_pipo_register.sv
// tb_pipo_register
//   Three instances run side by side:
//     dut_a : default parameters (WIDTH 32, DEPTH 1, reset value 0)
//     dut_b : DEPTH 3, RESET_VALUE 32'h12345678
//     dut_c : WIDTH 8
//   The reference model keeps, for each instance, a queue holding the last
//   DEPTH words captured since reset. The expected output is the oldest word
//   in that queue once it holds DEPTH entries. Until then it is RESET_VALUE.
module tb_pipo_register;

  localparam int                  D_B  = 3;
  localparam logic [31:0]         RV_B = 32'h12345678;

  logic        clock;
  logic        reset;
  logic [31:0] in_a, in_b;
  logic [7:0]  in_c;
  logic [31:0] ans_a, ans_b;
  logic [7:0]  ans_c;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  logic [31:0] exp_qa[$];
  logic [31:0] exp_qb[$];
  logic [7:0]  exp_qc[$];

  pipo_register dut_a (
    .inputseq(in_a), .answer(ans_a), .reset(reset), .clock(clock)
  );

  pipo_register #(.WIDTH(32), .DEPTH(D_B), .RESET_VALUE(RV_B)) dut_b (
    .inputseq(in_b), .answer(ans_b), .reset(reset), .clock(clock)
  );

  pipo_register #(.WIDTH(8)) dut_c (
    .inputseq(in_c), .answer(ans_c), .reset(reset), .clock(clock)
  );

  // Clock: 20-unit period.
  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  // Model: record each captured word. Reset empties the histories.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_qa.delete();
      exp_qb.delete();
      exp_qc.delete();
    end else begin
      exp_qa.push_back(in_a);
      if (exp_qa.size() > 1) void'(exp_qa.pop_front());
      exp_qb.push_back(in_b);
      if (exp_qb.size() > D_B) void'(exp_qb.pop_front());
      exp_qc.push_back(in_c);
      if (exp_qc.size() > 1) void'(exp_qc.pop_front());
    end
  end

  function automatic logic [31:0] model_a();
    return (exp_qa.size() == 1) ? exp_qa[0] : 32'h0;
  endfunction

  function automatic logic [31:0] model_b();
    return (exp_qb.size() == D_B) ? exp_qb[0] : RV_B;
  endfunction

  function automatic logic [7:0] model_c();
    return (exp_qc.size() == 1) ? exp_qc[0] : 8'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: check every DUT against the model on every falling edge.
  always @(negedge clock) begin
    if (checking) begin
      check("model_a", ans_a, model_a());
      check("model_b", ans_b, model_b());
      check("model_c", {24'h0, ans_c}, {24'h0, model_c()});
    end
  end

  // Driver: set the inputs, then let one rising edge pass.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [7:0] c);
    in_a = a;
    in_b = b;
    in_c = c;
    @(negedge clock);
  endtask

  // Pulse reset low between two edges and verify the immediate clear.
  task automatic reset_pulse(input logic [31:0] a, input logic [31:0] b, input logic [7:0] c);
    #3 reset = 1'b0;
    #1;
    check("async_clear_a", ans_a, 32'h0);
    check("async_clear_b", ans_b, RV_B);
    check("async_clear_c", {24'h0, ans_c}, 32'h0);
    in_a = a;
    in_b = b;
    in_c = c;
    #2 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    in_a  = $urandom;
    in_b  = $urandom;
    in_c  = 8'($urandom);
    #2 reset = 1'b0;
    checking = 1'b1;

    // Reset held with the clock running: outputs stay at their reset values.
    repeat (3) begin
      @(negedge clock);
      in_a = $urandom;
      in_b = $urandom;
      in_c = 8'($urandom);
    end
    check("rst_hold_a", ans_a, 32'h0);
    check("rst_hold_b", ans_b, RV_B);
    check("rst_hold_c", {24'h0, ans_c}, 32'h0);

    // Release reset well away from a rising edge.
    reset = 1'b1;

    // A held input shows up after the first edge and stays there.
    step(32'h7FFFFFFF, 32'h0, 8'h80);
    step(32'h7FFFFFFF, 32'h0, 8'h01);
    check("hold_7fff_a", ans_a, 32'h7FFFFFFF);
    check("w8_01", {24'h0, ans_c}, 32'h01);
    step(32'h7FFFFFFF, 32'h0, 8'h80);
    check("hold_7fff_a2", ans_a, 32'h7FFFFFFF);
    check("w8_80", {24'h0, ans_c}, 32'h80);

    // Consecutive words, each visible one edge later.
    step(32'hA5A5A5A5, 32'h0, 8'h5A);
    check("seq_a5", ans_a, 32'hA5A5A5A5);
    step(32'h5A5A5A5A, 32'h0, 8'hA5);
    check("seq_5a", ans_a, 32'h5A5A5A5A);
    check("w8_a5", {24'h0, ans_c}, 32'hA5);
    step(32'hFFFFFFFF, 32'h0, 8'hFF);
    check("seq_ff", ans_a, 32'hFFFFFFFF);
    step(32'hDEADBEEF, 32'h0, 8'h00);
    check("pre_rst_dead", ans_a, 32'hDEADBEEF);

    // Mid-operation reset. dut_b then sees a single 1 followed by zeros.
    reset_pulse(32'h0BADF00D, 32'h00000001, 8'h3C);
    @(negedge clock);
    check("post_rst_capture_a", ans_a, 32'h0BADF00D);
    check("post_rst_capture_c", {24'h0, ans_c}, 32'h3C);
    check("d3_edge1", ans_b, RV_B);
    in_b = 32'h0;
    @(negedge clock);
    check("d3_edge2", ans_b, RV_B);
    @(negedge clock);
    check("d3_edge3", ans_b, 32'h00000001);
    @(negedge clock);
    check("d3_edge4", ans_b, 32'h0);
    @(negedge clock);
    check("d3_edge5", ans_b, 32'h0);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      in_a = $urandom;
      in_b = $urandom;
      in_c = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) begin
        reset_pulse($urandom, $urandom, 8'($urandom_range(0, 255)));
      end
      @(negedge clock);
    end

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
